// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, opcodes and state encodings for alu_unit.
// S_DIV exists only when ALU_UNIT_DIV_EN is defined.
package alu_pkg;
    localparam int ALU_REG_WIDTH  = 34;
    localparam int ALU_ADDR_WIDTH = 5;
    localparam int ALU_OP_WIDTH   = 4;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_AND  = 2;
    localparam int OP_OR   = 3;
    localparam int OP_XOR  = 4;
    localparam int OP_SLL  = 5;
    localparam int OP_SRL  = 6;
    localparam int OP_SRA  = 7;
    localparam int OP_MUL  = 8;
    localparam int OP_DIVU = 9;
    localparam int OP_REMU = 10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef ALU_UNIT_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_WB   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MD_MUL  = 2'd0,
        MD_DIVU = 2'd1,
        MD_REMU = 2'd2
    } md_op_e;
endpackage

// File: rtl/seq_muldiv.sv
// seq_muldiv: one-bit-per-cycle shift-add multiplier and restoring divider.
// The divider datapath is present only when ALU_UNIT_DIV_EN is defined.
module seq_muldiv
    import alu_pkg::*;
#(
    parameter int W = ALU_REG_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  md_op_e       op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         done_o,
    output logic [W-1:0] result_o,
    output logic         div_zero_o
);
    localparam int CW = $clog2(W);

    logic          busy_q;
    logic [CW-1:0] cnt_q;
    md_op_e        op_q;
    logic [W-1:0]  acc_q, mq_q, md_q, acc_d, mq_d, md_d;

`ifdef ALU_UNIT_DIV_EN
    logic [W:0] r_sh, diff;
    // acc holds the partial remainder for division; a set diff[W] means the trial subtraction borrowed
    assign r_sh       = {acc_q, mq_q[W-1]};
    assign diff       = r_sh - {1'b0, md_q};
    assign acc_d      = op_q == MD_MUL ? (mq_q[0] ? acc_q + md_q : acc_q)
                                       : (diff[W] ? r_sh[W-1:0] : diff[W-1:0]);
    assign mq_d       = op_q == MD_MUL ? mq_q >> 1 : {mq_q[W-2:0], ~diff[W]};
    assign md_d       = op_q == MD_MUL ? md_q << 1 : md_q;
    assign div_zero_o = done_o && op_q != MD_MUL && md_q == '0;
`else
    assign acc_d      = mq_q[0] ? acc_q + md_q : acc_q;
    assign mq_d       = mq_q >> 1;
    assign md_d       = md_q << 1;
    assign div_zero_o = 1'b0;
`endif

    // done and result reflect the final iteration combinationally so the caller can latch on that edge
    assign done_o   = busy_q && cnt_q == CW'(W - 1);
    assign result_o = op_q == MD_DIVU ? mq_d : acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            op_q   <= MD_MUL;
            acc_q  <= '0;
            mq_q   <= '0;
            md_q   <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            op_q   <= op_i;
            acc_q  <= '0;
            mq_q   <= a_i;
            md_q   <= b_i;
        end else if (busy_q) begin
            busy_q <= !done_o;
            cnt_q  <= cnt_q + CW'(1);
            acc_q  <= acc_d;
            mq_q   <= mq_d;
            md_q   <= md_d;
        end
    end
endmodule

// File: rtl/alu_unit.sv
// alu_unit: single-cycle ALU ops plus iterative MUL/DIVU/REMU with register-file write-back.
// Define ALU_UNIT_DIV_EN to implement DIVU/REMU; otherwise opcodes 9/10 are illegal.
module alu_unit
    import alu_pkg::*;
#(
    parameter int REG_WIDTH  = ALU_REG_WIDTH,
    parameter int ADDR_WIDTH = ALU_ADDR_WIDTH,
    parameter int OP_WIDTH   = ALU_OP_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    input  logic [OP_WIDTH-1:0]   i_op,
    input  logic [REG_WIDTH-1:0]  i_data_b,
    input  logic [REG_WIDTH-1:0]  i_data_c,
    input  logic [ADDR_WIDTH-1:0] i_addr_dst,
    output logic                  o_ready,
    output logic                  o_wenable_reg_a,
    output logic [ADDR_WIDTH-1:0] o_address_reg_a,
    output logic [REG_WIDTH-1:0]  o_writedata_reg_a,
    output logic                  o_zero,
    output logic                  o_illegal,
    output logic                  o_div_zero
);
    state_e                      state_q;
    logic [ADDR_WIDTH-1:0]       dst_q, addr_q;
    logic [REG_WIDTH-1:0]        data_q, alu_res, md_res;
    logic signed [REG_WIDTH-1:0] sra_res;
    logic                        wen_q, zero_q, ill_q, dz_q;
    logic                        accept, is_single, is_mul, is_div, md_start, md_done, md_dz;
    logic [5:0]                  sh;
    md_op_e                      md_op;

    assign sh        = i_data_c[5:0];
    assign o_ready   = state_q == S_IDLE;
    assign accept    = i_valid && o_ready;
    assign is_single = i_op < OP_WIDTH'(OP_MUL);
    assign is_mul    = i_op == OP_WIDTH'(OP_MUL);
`ifdef ALU_UNIT_DIV_EN
    assign is_div    = i_op == OP_WIDTH'(OP_DIVU) || i_op == OP_WIDTH'(OP_REMU);
`else
    assign is_div    = 1'b0;
`endif
    assign md_start  = accept && (is_mul || is_div);
    assign md_op     = is_mul ? MD_MUL : (i_op == OP_WIDTH'(OP_REMU) ? MD_REMU : MD_DIVU);

    // shift amounts of REG_WIDTH or more naturally give 0 / all sign bits
    assign sra_res = $signed(i_data_b) >>> sh;
    assign alu_res = i_op == OP_WIDTH'(OP_ADD) ? i_data_b + i_data_c :
                     i_op == OP_WIDTH'(OP_SUB) ? i_data_b - i_data_c :
                     i_op == OP_WIDTH'(OP_AND) ? i_data_b & i_data_c :
                     i_op == OP_WIDTH'(OP_OR)  ? i_data_b | i_data_c :
                     i_op == OP_WIDTH'(OP_XOR) ? i_data_b ^ i_data_c :
                     i_op == OP_WIDTH'(OP_SLL) ? i_data_b << sh :
                     i_op == OP_WIDTH'(OP_SRL) ? i_data_b >> sh :
                                                 sra_res;

    seq_muldiv #(.W(REG_WIDTH)) u_muldiv (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (md_start),
        .op_i       (md_op),
        .a_i        (i_data_b),
        .b_i        (i_data_c),
        .done_o     (md_done),
        .result_o   (md_res),
        .div_zero_o (md_dz)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dst_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wen_q   <= 1'b0;
            zero_q  <= 1'b0;
            ill_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            wen_q <= 1'b0;
            ill_q <= 1'b0;
            dz_q  <= 1'b0;
            case (state_q)
                S_IDLE: if (accept) begin
                    if (is_single) begin
                        wen_q  <= 1'b1;
                        addr_q <= i_addr_dst;
                        data_q <= alu_res;
                        zero_q <= alu_res == '0;
                    end else if (is_mul) begin
                        state_q <= S_MUL;
                        dst_q   <= i_addr_dst;
`ifdef ALU_UNIT_DIV_EN
                    end else if (is_div) begin
                        state_q <= S_DIV;
                        dst_q   <= i_addr_dst;
`endif
                    end else begin
                        ill_q <= 1'b1;
                    end
                end
                S_WB: state_q <= S_IDLE;
                // write-back registers are loaded on the edge entering WB so the strobe coincides with WB
                default: if (md_done) begin
                    state_q <= S_WB;
                    wen_q   <= 1'b1;
                    addr_q  <= dst_q;
                    data_q  <= md_res;
                    zero_q  <= md_res == '0;
                    dz_q    <= md_dz;
                end
            endcase
        end
    end

    assign o_wenable_reg_a   = wen_q;
    assign o_address_reg_a   = addr_q;
    assign o_writedata_reg_a = data_q;
    assign o_zero            = zero_q;
    assign o_illegal         = ill_q;
    assign o_div_zero        = dz_q;
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed vectors with a write-back scoreboard and cycle-accurate latency checks.
// Expectations for opcodes 9/10 follow ALU_UNIT_DIV_EN.
module tb_alu_unit;
    localparam int W = 34;
    localparam logic [W-1:0] ONES = {W{1'b1}};
`ifdef ALU_UNIT_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam int DK = DIV_EN ? 1 : 2;

    logic         clk = 1'b0, rst_n = 1'b0, i_valid = 1'b0;
    logic [3:0]   i_op = '0;
    logic [W-1:0] i_data_b = '0, i_data_c = '0;
    logic [4:0]   i_addr_dst = '0;
    logic         o_ready, o_wenable_reg_a, o_zero, o_illegal, o_div_zero;
    logic [4:0]   o_address_reg_a;
    logic [W-1:0] o_writedata_reg_a;

    typedef struct {
        logic [4:0]   addr;
        logic [W-1:0] data;
        logic         dz;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    int   ill_q[$];
    int   cyc = 0, vectors = 0, miscompares = 0;

    alu_unit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_valid           (i_valid),
        .i_op              (i_op),
        .i_data_b          (i_data_b),
        .i_data_c          (i_data_c),
        .i_addr_dst        (i_addr_dst),
        .o_ready           (o_ready),
        .o_wenable_reg_a   (o_wenable_reg_a),
        .o_address_reg_a   (o_address_reg_a),
        .o_writedata_reg_a (o_writedata_reg_a),
        .o_zero            (o_zero),
        .o_illegal         (o_illegal),
        .o_div_zero        (o_div_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // kind: 0 no response expected, 1 write-back, 2 illegal pulse
    task automatic issue(input logic [3:0] op, input logic [W-1:0] b, input logic [W-1:0] c,
                         input logic [4:0] dst, input int kind, input logic [W-1:0] data,
                         input logic dz, output int t);
        int n = 0;
        bit multi;
        i_valid = 1'b1; i_op = op; i_data_b = b; i_data_c = c; i_addr_dst = dst;
        while (!o_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: op %0d not accepted after %0d cycles", op, n);
        end
        t = cyc + 1;
        multi = op == 4'd8 || (DIV_EN && (op == 4'd9 || op == 4'd10));
        if (kind == 1) exp_q.push_back('{dst, data, dz, multi ? t + W : t});
        else if (kind == 2) ill_q.push_back(t);
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        int   c;
        if (rst_n) begin
            if (o_wenable_reg_a) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_write: addr %0d data %h cycle %0d, required no write",
                             o_address_reg_a, o_writedata_reg_a, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (o_address_reg_a !== e.addr || o_writedata_reg_a !== e.data ||
                        o_zero !== (e.data == '0) || o_div_zero !== e.dz || cyc != e.cyc) begin
                        miscompares++;
                        $display("FAIL write: got addr %0d data %h zero %b dz %b cycle %0d, required addr %0d data %h zero %b dz %b cycle %0d",
                                 o_address_reg_a, o_writedata_reg_a, o_zero, o_div_zero, cyc,
                                 e.addr, e.data, e.data == '0, e.dz, e.cyc);
                    end
                end
            end else if (o_div_zero) begin
                vectors++;
                miscompares++;
                $display("FAIL div_zero_without_strobe: cycle %0d", cyc);
            end
            if (o_illegal) begin
                vectors++;
                if (ill_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_illegal: cycle %0d, required none", cyc);
                end else begin
                    c = ill_q.pop_front();
                    if (cyc != c) begin
                        miscompares++;
                        $display("FAIL illegal_cycle: got %0d required %0d", cyc, c);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, t2, busy;
        repeat (3) @(negedge clk);
        check("rst_wen", o_wenable_reg_a, 0);
        check("rst_data", o_writedata_reg_a, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", o_ready, 1);
        check("rst_addr", o_address_reg_a, 0);
        check("rst_flags", {o_zero, o_illegal, o_div_zero}, 0);

        issue(4'd0, ONES, 1, 5'd7, 1, '0, 0, t);
        issue(4'd7, 34'h2_0000_0000, 40, 5'd1, 1, ONES, 0, t);
        issue(4'd5, 1, 33, 5'd2, 1, 34'h2_0000_0000, 0, t);
        issue(4'd6, ONES, 34, 5'd0, 1, '0, 0, t);
        issue(4'd6, 34'h2_0000_0000, 33, 5'd3, 1, 1, 0, t);
        issue(4'd1, 0, 1, 5'd3, 1, ONES, 0, t);
        issue(4'd2, 34'h3F0F, 34'h0FF0, 5'd4, 1, 34'h0F00, 0, t);
        issue(4'd3, 34'h3F0F, 34'h0FF0, 5'd5, 1, 34'h3FFF, 0, t);

        issue(4'd0, 5, 6, 5'd2, 1, 11, 0, t);
        issue(4'd4, 34'hF0, 34'hFF, 5'd3, 1, 34'h0F, 0, t2);
        check("b2b_accept", t2, t + 1);
        issue(4'd1, 10, 3, 5'd4, 1, 7, 0, t2);
        check("b2b_accept2", t2, t + 2);

        issue(4'd8, 12345, 678, 5'd9, 1, 8369910, 0, t);
        i_valid = 1'b1; i_op = 4'd8; i_data_b = ONES; i_data_c = ONES; i_addr_dst = 5'd10;
        busy = 0;
        repeat (W + 1) begin
            busy += int'(o_ready);
            @(negedge clk);
        end
        check("mul_busy_ready", busy, 0);
        issue(4'd8, ONES, ONES, 5'd10, 1, 1, 0, t2);
        check("held_accept_cycle", t2, t + 36);

        issue(4'd9, 100, 7, 5'd11, DK, 14, 0, t);
        issue(4'd10, 100, 7, 5'd12, DK, 2, 0, t);
        issue(4'd9, 100, 0, 5'd13, DK, ONES, 1, t);
        issue(4'd10, 100, 0, 5'd14, DK, 100, 1, t);

        issue(4'd0, 2, 2, 5'd15, 1, 4, 0, t);
        issue(4'd13, 1, 1, 5'd16, 2, '0, 0, t);
        @(negedge clk);
        check("hold_data", o_writedata_reg_a, 4);
        check("hold_addr", o_address_reg_a, 15);

        issue(4'd8, 3, 5, 5'd20, 0, '0, 0, t);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midop_rst_data", o_writedata_reg_a, 0);
        check("midop_rst_wen", o_wenable_reg_a, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midop_rst_ready", o_ready, 1);
        repeat (40) @(negedge clk);
        issue(4'd0, 2, 3, 5'd6, 1, 5, 0, t);
        repeat (5) @(negedge clk);
        check("pending_writes", exp_q.size(), 0);
        check("pending_illegal", ill_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
